interrupt_sequencer: RTL and testbench
======================================

// Module: interrupt_sequencer
// PURPOSE
//  Interrupt/BRK/reset entry sequencer: the write-side counterpart to PC loading.
//  Pushes PCH, PCL and P onto the stack, then fetches the vector and loads it into the
//  PC register through its pcl/pch write ports.
//  Sits in the CPU beside the PC register and the stack pointer; takes over the bus for 7 cycles.
// PARAMETERS
//  VEC_NMI     16'hFFFA  NMI vector low-byte address (high byte at +1)
//  VEC_RESET   16'hFFFC  reset vector low-byte address
//  VEC_IRQ     16'hFFFE  IRQ/BRK vector low-byte address
//  STACK_PAGE  8'h01     high byte of every stack address
// PORTS
//  clk        in   1   system clock
//  reset      in   1   synchronous, active-high reset
//  cpu_en     in   1   CPU clock enable; state advances only when 1
//  req        in   1   start request, sampled in IDLE with cpu_en=1
//  src        in   2   0=IRQ 1=BRK 2=NMI 3=RESET; latched on accept
//  pc_in      in   16  current PC; latched on accept
//  p_in       in   8   current status register; latched on accept
//  s_in       in   8   current stack pointer; latched on accept
//  rdata      in   8   memory read data, valid in the same cycle as addr
//  busy       out  1   1 in every non-IDLE state
//  done       out  1   1-cycle pulse in VEC_HI, qualified by cpu_en
//  addr       out  16  bus address
//  wdata      out  8   bus write data
//  we         out  1   memory write enable
//  s_out      out  8   new stack pointer value
//  s_write    out  1   stack pointer write enable
//  set_i      out  1   set the I flag
//  pcl_write  out  1   load pc_wd into PCL
//  pch_write  out  1   load pc_wd into PCH
//  pc_wd      out  8   PC load data (=rdata during vector fetch)
// BEHAVIOUR
//  - Reset: state=IDLE; busy, done, we, s_write, set_i, pcl_write, pch_write = 0;
//    addr, wdata, s_out, pc_wd = 0; latched registers cleared.
//  - Outputs are combinational from the state and latched registers. When cpu_en=0,
//    the state holds and every strobe (we, s_write, set_i, pcl/pch_write, done) is forced to 0.
//  - Accept: in IDLE with req=1 and cpu_en=1, latch src, pc, p and s, then go to DUMMY1.
//    req is ignored while busy.
//  - Sequence (one state per enabled cycle, 7 cycles total):
//    DUMMY1: addr=pc.
//    DUMMY2: addr=pc.
//    PUSH_PCH: addr={STACK_PAGE,s}, wdata=pc[15:8].
//    PUSH_PCL: addr={STACK_PAGE,s}, wdata=pc[7:0].
//    PUSH_P: addr={STACK_PAGE,s}, wdata=p|8'h20 with bit4=(src==BRK).
//    VEC_LO: addr=vec, pcl_write=1, pc_wd=rdata, set_i=1.
//    VEC_HI: addr=vec+1, pch_write=1, pc_wd=rdata, done=1. Then return to IDLE.
//  - Each PUSH state drives we=1 (0 when src=RESET) and s_write=1 with s_out=s-1.
//    It also decrements the internal s.
//  - s is 8-bit and wraps within the page: 8'h00-1 = 8'hFF. Addresses never leave STACK_PAGE.
//  - vec = VEC_RESET if src=3, VEC_NMI if src=2, otherwise VEC_IRQ.
//  - reset asserted in any state returns to IDLE on the next edge; no further strobes follow.
//  - Stalls (cpu_en=0) inside the sequence must not duplicate or drop any write or S decrement.
// TESTING
//  - IRQ with pc=16'h8123, p=8'h81, s=8'hFD, rdata FFFE=34 FFFF=12:
//    writes 01FD=81, 01FC=23, 01FB=A1, s_out FC/FB/FA, PC load 1234, done at cycle 7.
//  - BRK with the same inputs: third push writes 8'hB1. NMI reads FFFA/FFFB.
//  - RESET with s=8'h00: we never asserted, addr 0100/01FF/01FE, s_out FF/FE/FD,
//    vector read from FFFC.
//  - Assert cpu_en=0 for 3 cycles during PUSH_PCL: exactly 3 writes and 3 s_write total,
//    and done is delayed by 3 cycles.
//  - Assert reset during PUSH_P: next cycle busy=0, and no pcl_write/pch_write occurs.
//  - req held high across done: a new sequence starts on the cycle after VEC_HI.
//    No req accepted while busy.

Source files
------------

// File: rtl/interrupt_sequencer.sv
// Interrupt/BRK/reset entry sequencer: pushes PCH, PCL and P,
// then fetches the vector into the PC over a 7-cycle bus takeover.
module interrupt_sequencer #(
  parameter logic [15:0] VEC_NMI    = 16'hFFFA,
  parameter logic [15:0] VEC_RESET  = 16'hFFFC,
  parameter logic [15:0] VEC_IRQ    = 16'hFFFE,
  parameter logic [7:0]  STACK_PAGE = 8'h01
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_en,
  input  logic        req,
  input  logic [1:0]  src,
  input  logic [15:0] pc_in,
  input  logic [7:0]  p_in,
  input  logic [7:0]  s_in,
  input  logic [7:0]  rdata,
  output logic        busy,
  output logic        done,
  output logic [15:0] addr,
  output logic [7:0]  wdata,
  output logic        we,
  output logic [7:0]  s_out,
  output logic        s_write,
  output logic        set_i,
  output logic        pcl_write,
  output logic        pch_write,
  output logic [7:0]  pc_wd
);

  localparam logic [1:0] SRC_BRK = 2'd1;
  localparam logic [1:0] SRC_NMI = 2'd2;
  localparam logic [1:0] SRC_RST = 2'd3;

  typedef enum logic [2:0] {
    IDLE, DUMMY1, DUMMY2, PUSH_PCH,
    PUSH_PCL, PUSH_P, VEC_LO, VEC_HI
  } state_t;

  state_t      state_q, state_d, nxt;
  logic [1:0]  src_q, src_d;
  logic [15:0] pc_q, pc_d;
  logic [7:0]  p_q, p_d;
  logic [7:0]  s_q, s_d;
  logic [15:0] vec;
  logic        push;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      src_q   <= '0;
      pc_q    <= '0;
      p_q     <= '0;
      s_q     <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      pc_q    <= pc_d;
      p_q     <= p_d;
      s_q     <= s_d;
    end
  end

  always_comb begin
    vec = VEC_IRQ;
    if (src_q == SRC_RST)
      vec = VEC_RESET;
    else if (src_q == SRC_NMI)
      vec = VEC_NMI;
  end

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    pc_d      = pc_q;
    p_d       = p_q;
    s_d       = s_q;
    nxt       = IDLE;
    push      = 1'b0;
    busy      = (state_q != IDLE);
    done      = 1'b0;
    addr      = '0;
    wdata     = '0;
    we        = 1'b0;
    s_out     = '0;
    s_write   = 1'b0;
    set_i     = 1'b0;
    pcl_write = 1'b0;
    pch_write = 1'b0;
    pc_wd     = '0;
    unique case (state_q)
      IDLE: begin
        if (cpu_en && req) begin
          src_d   = src;
          pc_d    = pc_in;
          p_d     = p_in;
          s_d     = s_in;
          state_d = DUMMY1;
        end
      end
      DUMMY1: begin
        addr = pc_q;
        nxt  = DUMMY2;
      end
      DUMMY2: begin
        addr = pc_q;
        nxt  = PUSH_PCH;
      end
      PUSH_PCH: begin
        wdata = pc_q[15:8];
        push  = 1'b1;
        nxt   = PUSH_PCL;
      end
      PUSH_PCL: begin
        wdata = pc_q[7:0];
        push  = 1'b1;
        nxt   = PUSH_P;
      end
      PUSH_P: begin
        wdata = {p_q[7:6], 1'b1,
                 (src_q == SRC_BRK), p_q[3:0]};
        push  = 1'b1;
        nxt   = VEC_LO;
      end
      VEC_LO: begin
        addr      = vec;
        pc_wd     = rdata;
        pcl_write = cpu_en;
        set_i     = cpu_en;
        nxt       = VEC_HI;
      end
      VEC_HI: begin
        addr      = vec + 16'd1;
        pc_wd     = rdata;
        pch_write = cpu_en;
        done      = cpu_en;
        nxt       = IDLE;
      end
    endcase
    // Stack pushes only commit on enabled cycles, so stalls never
    // repeat a write or skip a decrement.
    if (push) begin
      addr    = {STACK_PAGE, s_q};
      s_out   = s_q - 8'd1;
      we      = cpu_en && (src_q != SRC_RST);
      s_write = cpu_en;
      if (cpu_en)
        s_d = s_q - 8'd1;
    end
    if (state_q != IDLE && cpu_en)
      state_d = nxt;
  end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed bench for interrupt_sequencer: vector table plus
// hand-written stall, reset and back-to-back sequences.
module tb_interrupt_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_en;
  logic        req;
  logic [1:0]  src;
  logic [15:0] pc_in;
  logic [7:0]  p_in;
  logic [7:0]  s_in;
  logic [7:0]  rdata;
  logic        busy;
  logic        done;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic        we;
  logic [7:0]  s_out;
  logic        s_write;
  logic        set_i;
  logic        pcl_write;
  logic        pch_write;
  logic [7:0]  pc_wd;

  interrupt_sequencer dut (
    .clk(clk), .reset(reset), .cpu_en(cpu_en), .req(req),
    .src(src), .pc_in(pc_in), .p_in(p_in), .s_in(s_in),
    .rdata(rdata), .busy(busy), .done(done), .addr(addr),
    .wdata(wdata), .we(we), .s_out(s_out), .s_write(s_write),
    .set_i(set_i), .pcl_write(pcl_write),
    .pch_write(pch_write), .pc_wd(pc_wd)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        en;
    logic        rq;
    logic [1:0]  sr;
    logic [15:0] pc;
    logic [7:0]  p;
    logic [7:0]  s;
    logic [7:0]  rd;
  } in_t;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        we;
    logic [7:0]  s_out;
    logic        s_write;
    logic        set_i;
    logic        pcl_write;
    logic        pch_write;
    logic [7:0]  pc_wd;
  } out_t;

  typedef struct {
    in_t  i;
    out_t o;
  } vec_t;

  vec_t tbl[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cnt_we, cnt_sw, cnt_pl, cnt_ph, cnt_si;
  int   cyc_n, done_at;

  function automatic in_t I(bit en, bit rq, logic [1:0] sr,
                            logic [15:0] pc, logic [7:0] p,
                            logic [7:0] s, logic [7:0] rd);
    I = '{en, rq, sr, pc, p, s, rd};
  endfunction

  function automatic out_t O(bit b, bit d, logic [15:0] a,
                             logic [7:0] wd, bit w,
                             logic [7:0] so, bit sw, bit si,
                             bit pl, bit ph, logic [7:0] pw);
    O = '{b, d, a, wd, w, so, sw, si, pl, ph, pw};
  endfunction

  function automatic out_t cur();
    cur = '{busy, done, addr, wdata, we, s_out, s_write,
            set_i, pcl_write, pch_write, pc_wd};
  endfunction

  task automatic row(in_t i, out_t o);
    vec_t v;
    v.i = i;
    v.o = o;
    tbl.push_back(v);
  endtask

  task automatic drive(in_t i);
    cpu_en = i.en;
    req    = i.rq;
    src    = i.sr;
    pc_in  = i.pc;
    p_in   = i.p;
    s_in   = i.s;
    rdata  = i.rd;
  endtask

  task automatic check(string nm, logic [63:0] act,
                       logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clr();
    cnt_we = 0;
    cnt_sw = 0;
    cnt_pl = 0;
    cnt_ph = 0;
    cnt_si = 0;
    cyc_n = 0;
    done_at = -1;
  endtask

  task automatic step();
    #1;
    cnt_we += int'(we);
    cnt_sw += int'(s_write);
    cnt_pl += int'(pcl_write);
    cnt_ph += int'(pch_write);
    cnt_si += int'(set_i);
    if (done) done_at = cyc_n;
    cyc_n++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(I(1, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    @(negedge clk);
    check("reset_state", 64'(cur()), 64'(out_t'(0)));
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // IDLE with cpu_en low ignores req
    row(I(0,1,0,16'h8123,8'h81,8'hFD,0), O(0,0,0,0,0,0,0,0,0,0,0));
    row(I(1,0,0,16'h8123,8'h81,8'hFD,0), O(0,0,0,0,0,0,0,0,0,0,0));
    // IRQ
    row(I(1,1,0,16'h8123,8'h81,8'hFD,0), O(0,0,0,0,0,0,0,0,0,0,0));
    row(I(1,0,0,0,0,0,0), O(1,0,16'h8123,0,0,0,0,0,0,0,0));
    row(I(1,0,0,0,0,0,0), O(1,0,16'h8123,0,0,0,0,0,0,0,0));
    row(I(1,0,0,0,0,0,0), O(1,0,16'h01FD,8'h81,1,8'hFC,1,0,0,0,0));
    row(I(1,0,0,0,0,0,0), O(1,0,16'h01FC,8'h23,1,8'hFB,1,0,0,0,0));
    row(I(1,0,0,0,0,0,0), O(1,0,16'h01FB,8'hA1,1,8'hFA,1,0,0,0,0));
    row(I(1,0,0,0,0,0,8'h34), O(1,0,16'hFFFE,0,0,0,0,1,1,0,8'h34));
    row(I(1,0,0,0,0,0,8'h12), O(1,1,16'hFFFF,0,0,0,0,0,0,1,8'h12));
    row(I(1,0,0,0,0,0,0), O(0,0,0,0,0,0,0,0,0,0,0));
    // BRK
    row(I(1,1,1,16'h8123,8'h81,8'hFD,0), O(0,0,0,0,0,0,0,0,0,0,0));
    row(I(1,0,0,0,0,0,0), O(1,0,16'h8123,0,0,0,0,0,0,0,0));
    row(I(1,0,0,0,0,0,0), O(1,0,16'h8123,0,0,0,0,0,0,0,0));
    row(I(1,0,0,0,0,0,0), O(1,0,16'h01FD,8'h81,1,8'hFC,1,0,0,0,0));
    row(I(1,0,0,0,0,0,0), O(1,0,16'h01FC,8'h23,1,8'hFB,1,0,0,0,0));
    row(I(1,0,0,0,0,0,0), O(1,0,16'h01FB,8'hB1,1,8'hFA,1,0,0,0,0));
    row(I(1,0,0,0,0,0,8'h34), O(1,0,16'hFFFE,0,0,0,0,1,1,0,8'h34));
    row(I(1,0,0,0,0,0,8'h12), O(1,1,16'hFFFF,0,0,0,0,0,0,1,8'h12));
    row(I(1,0,0,0,0,0,0), O(0,0,0,0,0,0,0,0,0,0,0));
    // NMI, p=FF clears B
    row(I(1,1,2,16'h2345,8'hFF,8'h80,0), O(0,0,0,0,0,0,0,0,0,0,0));
    row(I(1,0,0,0,0,0,0), O(1,0,16'h2345,0,0,0,0,0,0,0,0));
    row(I(1,0,0,0,0,0,0), O(1,0,16'h2345,0,0,0,0,0,0,0,0));
    row(I(1,0,0,0,0,0,0), O(1,0,16'h0180,8'h23,1,8'h7F,1,0,0,0,0));
    row(I(1,0,0,0,0,0,0), O(1,0,16'h017F,8'h45,1,8'h7E,1,0,0,0,0));
    row(I(1,0,0,0,0,0,0), O(1,0,16'h017E,8'hEF,1,8'h7D,1,0,0,0,0));
    row(I(1,0,0,0,0,0,8'h78), O(1,0,16'hFFFA,0,0,0,0,1,1,0,8'h78));
    row(I(1,0,0,0,0,0,8'h56), O(1,1,16'hFFFB,0,0,0,0,0,0,1,8'h56));
    row(I(1,0,0,0,0,0,0), O(0,0,0,0,0,0,0,0,0,0,0));
    // RESET, s wraps, no writes, done gated by cpu_en
    row(I(1,1,3,16'hC000,8'h00,8'h00,0), O(0,0,0,0,0,0,0,0,0,0,0));
    row(I(1,0,0,0,0,0,0), O(1,0,16'hC000,0,0,0,0,0,0,0,0));
    row(I(1,0,0,0,0,0,0), O(1,0,16'hC000,0,0,0,0,0,0,0,0));
    row(I(1,0,0,0,0,0,0), O(1,0,16'h0100,8'hC0,0,8'hFF,1,0,0,0,0));
    row(I(1,0,0,0,0,0,0), O(1,0,16'h01FF,8'h00,0,8'hFE,1,0,0,0,0));
    row(I(1,0,0,0,0,0,0), O(1,0,16'h01FE,8'h20,0,8'hFD,1,0,0,0,0));
    row(I(1,0,0,0,0,0,8'h00), O(1,0,16'hFFFC,0,0,0,0,1,1,0,8'h00));
    row(I(0,0,0,0,0,0,8'hF0), O(1,0,16'hFFFD,0,0,0,0,0,0,0,8'hF0));
    row(I(1,0,0,0,0,0,8'hF0), O(1,1,16'hFFFD,0,0,0,0,0,0,1,8'hF0));
    row(I(1,0,0,0,0,0,0), O(0,0,0,0,0,0,0,0,0,0,0));

    do_reset();
    foreach (tbl[k]) begin
      drive(tbl[k].i);
      #1;
      check($sformatf("row%0d", k), 64'(cur()), 64'(tbl[k].o));
      @(negedge clk);
    end

    // Stall for 3 cycles inside PUSH_PCL
    do_reset();
    clr();
    drive(I(1, 1, 0, 16'h8123, 8'h81, 8'hFD, 0));
    step();
    req = 1'b0;
    repeat (3) step();
    cpu_en = 1'b0;
    repeat (3) step();
    cpu_en = 1'b1;
    for (int k = 0; k < 20 && done_at < 0; k++) step();
    check("stall_done_cycle", 64'(done_at), 64'(10));
    check("stall_we_count", 64'(cnt_we), 64'(3));
    check("stall_sw_count", 64'(cnt_sw), 64'(3));
    check("stall_pcl_count", 64'(cnt_pl), 64'(1));
    check("stall_pch_count", 64'(cnt_ph), 64'(1));
    check("stall_seti_count", 64'(cnt_si), 64'(1));

    // Reset asserted during PUSH_P
    do_reset();
    clr();
    drive(I(1, 1, 0, 16'h8123, 8'h81, 8'hFD, 0));
    step();
    req = 1'b0;
    repeat (4) step();
    #1;
    check("rst_at_push_p", 64'(addr), 64'(16'h01FB));
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    check("rst_busy", 64'(busy), 64'(0));
    repeat (10) step();
    check("rst_no_pcl", 64'(cnt_pl), 64'(0));
    check("rst_no_pch", 64'(cnt_ph), 64'(0));

    // req held: no re-latch while busy, restart after VEC_HI
    do_reset();
    clr();
    drive(I(1, 1, 0, 16'h4567, 8'h00, 8'h10, 0));
    step();
    pc_in = 16'hABCD;
    src   = 2'd3;
    check("held_latched_pc", 64'(addr), 64'(16'h4567));
    repeat (6) step();
    check("held_done", 64'(done), 64'(1));
    check("held_we_count", 64'(cnt_we), 64'(3));
    step();
    check("held_idle_gap", 64'(busy), 64'(0));
    step();
    check("held_restart_busy", 64'(busy), 64'(1));
    check("held_restart_pc", 64'(addr), 64'(16'hABCD));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
